// File: rtl/audio_playback_ctrl.sv
// SRAM-to-DAC playback sequencer: one serializer start per LRCK frame, with speed skip/repeat.
// Optional build macro AUDIO_PLAYBACK_LOOP_EN: wrap to address 0 at the end instead of idling.
module audio_playback_ctrl #(
    parameter int unsigned ADDR_W    = 20,
    parameter int unsigned WORD_BITS = 16
) (
    input  logic              i_BCLK,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic [2:0]        i_speed,
    input  logic [ADDR_W-1:0] i_end_addr,
    input  logic              i_daclrck,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_rd,
    output logic              o_ser_start,
    output logic              o_done,
    output logic [2:0]        o_state
);

    localparam int unsigned CntW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WORD_BITS - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWaitLr = 3'd1,
        StFetch  = 3'd2,
        StSend   = 3'd3,
        StPaused = 3'd4
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        rep_cnt_q;
    logic [CntW-1:0]   bit_cnt_q;
    logic              lr_prev_q;
    logic              rd_q;
    logic              ser_start_q;
    logic              done_q;

    logic              lr_fall;
    logic              rep_hold;
    logic [3:0]        step;
    logic [ADDR_W:0]   next_addr;
    logic              past_end;
    logic [2:0]        rep_cnt_nxt;

    // Extra top bit on next_addr keeps an address-space overflow visible as past_end.
    always_comb begin
        lr_fall  = lr_prev_q & ~i_daclrck;
        rep_hold = !i_fast && (rep_cnt_q < i_speed);
        if (i_fast) begin
            step = {1'b0, i_speed} + 4'd1;
        end else if (rep_hold) begin
            step = 4'd0;
        end else begin
            step = 4'd1;
        end
        next_addr   = {1'b0, addr_q} + {{(ADDR_W - 3){1'b0}}, step};
        past_end    = next_addr > {1'b0, i_end_addr};
        rep_cnt_nxt = rep_hold ? (rep_cnt_q + 3'd1) : 3'd0;
    end

    always_ff @(posedge i_BCLK or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            rep_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            lr_prev_q   <= 1'b0;
            rd_q        <= 1'b0;
            ser_start_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            lr_prev_q   <= i_daclrck;
            ser_start_q <= 1'b0;
            done_q      <= 1'b0;
            if (i_stop) begin
                state_q   <= StIdle;
                addr_q    <= '0;
                rep_cnt_q <= '0;
                bit_cnt_q <= '0;
                rd_q      <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (i_start) begin
                            state_q   <= StWaitLr;
                            addr_q    <= '0;
                            rep_cnt_q <= '0;
                        end
                    end
                    StWaitLr: begin
                        if (i_pause) begin
                            state_q <= StPaused;
                        end else if (lr_fall) begin
                            state_q     <= StFetch;
                            rd_q        <= 1'b1;
                            ser_start_q <= 1'b1;
                            bit_cnt_q   <= '0;
                        end
                    end
                    StFetch: state_q <= StSend;
                    StSend: begin
                        if (bit_cnt_q == LastBit) begin
                            bit_cnt_q <= '0;
                            rd_q      <= 1'b0;
                            if (past_end) begin
                                done_q    <= 1'b1;
                                addr_q    <= '0;
                                rep_cnt_q <= '0;
`ifdef AUDIO_PLAYBACK_LOOP_EN
                                state_q   <= StWaitLr;
`else
                                state_q   <= StIdle;
`endif
                            end else begin
                                addr_q    <= next_addr[ADDR_W-1:0];
                                rep_cnt_q <= rep_cnt_nxt;
                                state_q   <= i_pause ? StPaused : StWaitLr;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    StPaused: begin
                        if (i_start) begin
                            state_q <= StWaitLr;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign o_sram_addr = addr_q;
    assign o_sram_rd   = rd_q;
    assign o_ser_start = ser_start_q;
    assign o_done      = done_q;
    assign o_state     = state_q;

endmodule

// File: tb/tb_audio_playback_ctrl.sv
// Directed bench for audio_playback_ctrl; a 4-bit-address instance exercises the end-carry case.
module tb_audio_playback_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, pause = 1'b0, stop = 1'b0, fast = 1'b0;
    logic [2:0]  speed = 3'd0;
    logic [19:0] end_addr = 20'd0;
    logic        lrck = 1'b0;
    logic        start2 = 1'b0;
    logic [3:0]  end2 = 4'hF;

    logic [19:0] o_addr;
    logic        o_rd, o_ser, o_done;
    logic [2:0]  o_state;
    logic [3:0]  o2_addr;
    logic        o2_rd, o2_ser, o2_done;
    logic [2:0]  o2_state;

    audio_playback_ctrl #(.ADDR_W(20), .WORD_BITS(16)) dut (
        .i_BCLK(clk), .i_rst(rst), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_fast(fast), .i_speed(speed), .i_end_addr(end_addr), .i_daclrck(lrck),
        .o_sram_addr(o_addr), .o_sram_rd(o_rd), .o_ser_start(o_ser), .o_done(o_done),
        .o_state(o_state)
    );

    audio_playback_ctrl #(.ADDR_W(4), .WORD_BITS(16)) dut_c (
        .i_BCLK(clk), .i_rst(rst), .i_start(start2), .i_pause(1'b0), .i_stop(stop),
        .i_fast(fast), .i_speed(speed), .i_end_addr(end2), .i_daclrck(lrck),
        .o_sram_addr(o2_addr), .o_sram_rd(o2_rd), .o_ser_start(o2_ser), .o_done(o2_done),
        .o_state(o2_state)
    );

    always #5 clk = ~clk;

    // LRCK period of 32 BCLKs, changing on the inactive edge.
    int lr_cnt = 0;
    always @(negedge clk) begin
        lr_cnt = lr_cnt + 1;
        if (lr_cnt == 16) begin
            lr_cnt = 0;
            lrck = ~lrck;
        end
    end

    int          n_assert = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          done2_cnt = 0;
    logic [19:0] cap_q[$];
    logic [19:0] cap2_q[$];
    logic [19:0] exp_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (o_ser) cap_q.push_back(o_addr);
            if (o_done) done_cnt = done_cnt + 1;
            if (o2_ser) cap2_q.push_back(20'(o2_addr));
            if (o2_done) done2_cnt = done2_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_caps(input string tag, input logic [19:0] caps[$]);
        chk({tag, "_len"}, caps.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < caps.size(); i++) begin
            chk($sformatf("%s_%0d", tag, i), 32'(caps[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int bound);
        int k = 0;
        while (done_cnt == base && k < bound) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk(tag, done_cnt - base, 1);
    endtask

    initial begin
        int k;
        int base;

        // Reset state
        @(negedge clk);
        chk("rst_state", o_state, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_rd", o_rd, 0);
        chk("rst_ser", o_ser, 0);
        chk("rst_done", o_done, 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);

        // Normal speed, end=3
        end_addr = 20'd3; speed = 3'd0; fast = 1'b0;
        cap_q.delete(); base = done_cnt;
        pulse_start();
        wait_done("t1_done", base, 400);
        exp_q = '{20'd0, 20'd1, 20'd2, 20'd3};
        chk_caps("t1_addr", cap_q);
        chk("t1_state_idle", o_state, 0);
        chk("t1_rd_low", o_rd, 0);

        // Slow x3, end=1
        end_addr = 20'd1; speed = 3'd2; fast = 1'b0;
        cap_q.delete(); base = done_cnt;
        pulse_start();
        wait_done("t2_done", base, 600);
        exp_q = '{20'd0, 20'd0, 20'd0, 20'd1, 20'd1, 20'd1};
        chk_caps("t2_addr", cap_q);

        // Fast skip, end=4
        end_addr = 20'd4; speed = 3'd1; fast = 1'b1;
        cap_q.delete(); base = done_cnt;
        pulse_start();
        wait_done("t3_done", base, 400);
        exp_q = '{20'd0, 20'd2, 20'd4};
        chk_caps("t3_addr", cap_q);
        chk("t3_state_idle", o_state, 0);

        // Carry: 4-bit address space fully used, last step overflows
        speed = 3'd3; fast = 1'b1;
        cap2_q.delete(); base = done2_cnt;
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        k = 0;
        while (done2_cnt == base && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        chk("carry_done", done2_cnt - base, 1);
        exp_q = '{20'd0, 20'd4, 20'd8, 20'd12};
        chk_caps("carry_addr", cap2_q);
        chk("carry_state_idle", o2_state, 0);

        // Pause during word at addr 5, hold three frames, resume at 6
        end_addr = 20'd10; speed = 3'd0; fast = 1'b0;
        cap_q.delete();
        pulse_start();
        k = 0;
        while (cap_q.size() < 6 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("pause_reach5", cap_q.size() >= 6, 1);
        pause = 1'b1;
        k = 0;
        while (o_state != 3'd4 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("pause_state", o_state, 4);
        repeat (96) @(negedge clk);
        chk("pause_no_ser", cap_q.size(), 6);
        chk("pause_rd_low", o_rd, 0);
        chk("pause_held_addr", o_addr, 6);
        chk("pause_still", o_state, 4);
        pause = 1'b0;
        pulse_start();
        k = 0;
        while (cap_q.size() < 7 && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        chk("resume_len", cap_q.size(), 7);
        if (cap_q.size() >= 7) chk("resume_addr", 32'(cap_q[6]), 6);

        // Stop mid-SEND
        repeat (5) @(negedge clk);
        chk("stop_in_send", o_state, 3);
        base = done_cnt;
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        chk("stop_state", o_state, 0);
        chk("stop_addr", o_addr, 0);
        chk("stop_rd", o_rd, 0);
        repeat (40) @(negedge clk);
        chk("stop_no_done", done_cnt - base, 0);
        chk("stop_stays_idle", o_state, 0);

        // Asynchronous reset during FETCH at addr 2
        pulse_start();
        k = 0;
        while (!(o_ser && o_addr == 20'd2) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("rst_pre_fetch", o_state, 2);
        rst = 1'b1;
        #1;
        chk("arst_ser", o_ser, 0);
        chk("arst_rd", o_rd, 0);
        chk("arst_state", o_state, 0);
        chk("arst_addr", o_addr, 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(negedge clk);

`ifdef AUDIO_PLAYBACK_LOOP_EN
        // Looping playback, end=1
        end_addr = 20'd1; speed = 3'd0; fast = 1'b0;
        cap_q.delete(); base = done_cnt;
        pulse_start();
        k = 0;
        while (cap_q.size() < 5 && k < 600) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        exp_q = '{20'd0, 20'd1, 20'd0, 20'd1, 20'd0};
        chk_caps("loop_addr", cap_q);
        chk("loop_done_cnt", done_cnt - base, 2);
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
        chk("loop_stop_state", o_state, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
